// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO with per-bit direction, atomic set/clear and edge interrupts.
// Zero-wait-state slave; HADDR[4:2] selects one of eight word registers.

module ahb_gpio_irq_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  input  logic ie_rise,
  input  logic ie_fall,
  input  logic clr,
  output logic status
);
  logic prev_q, prev_d;
  logic status_q, status_d;
  logic rise, fall;

  // A new edge outranks a W1C landing on the same cycle.
  always_comb begin
    rise     = sync_in & ~prev_q;
    fall     = ~sync_in & prev_q;
    prev_d   = sync_in;
    status_d = (status_q & ~clr) | (rise & ie_rise) | (fall & ie_fall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;
endmodule

module ahb_gpio_irq #(
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  input  logic [GPIO_WIDTH-1:0] GPIOIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [GPIO_WIDTH-1:0] GPIOOUT,
  output logic [GPIO_WIDTH-1:0] GPIOEN,
  output logic                  IRQ
);
  localparam int W = GPIO_WIDTH;

  typedef enum logic [2:0] {
    OFF_DATA    = 3'd0,
    OFF_DIR     = 3'd1,
    OFF_OUTSET  = 3'd2,
    OFF_OUTCLR  = 3'd3,
    OFF_IE_RISE = 3'd4,
    OFF_IE_FALL = 3'd5,
    OFF_STATUS  = 3'd6,
    OFF_RSVD    = 3'd7
  } off_e;

  typedef struct packed {
    logic valid;
    logic write;
    off_e off;
  } dph_t;

  dph_t   dph_q, dph_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] dir_q, dir_d;
  logic [W-1:0] ie_rise_q, ie_rise_d;
  logic [W-1:0] ie_fall_q, ie_fall_d;
  logic [W-1:0] status, status_clr, sync_in, wdata, rval;
  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic         wr;

  always_comb begin
    dph_d = '0;
    if (HSEL && HREADY && HTRANS[1]) begin
      dph_d.valid = 1'b1;
      dph_d.write = HWRITE;
      dph_d.off   = off_e'(HADDR[4:2]);
    end
  end

  always_comb begin
    sync_d[0] = GPIOIN;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  assign sync_in = sync_q[SYNC_STAGES-1];

  assign wr    = dph_q.valid & dph_q.write;
  assign wdata = HWDATA[W-1:0];

  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    ie_rise_d  = ie_rise_q;
    ie_fall_d  = ie_fall_q;
    status_clr = '0;
    if (wr) begin
      case (dph_q.off)
        OFF_DATA:    out_d      = wdata;
        OFF_DIR:     dir_d      = wdata;
        OFF_OUTSET:  out_d      = out_q | wdata;
        OFF_OUTCLR:  out_d      = out_q & ~wdata;
        OFF_IE_RISE: ie_rise_d  = wdata;
        OFF_IE_FALL: ie_fall_d  = wdata;
        OFF_STATUS:  status_clr = wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dph_q     <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      ie_rise_q <= '0;
      ie_fall_q <= '0;
      sync_q    <= '0;
    end else begin
      dph_q     <= dph_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      ie_rise_q <= ie_rise_d;
      ie_fall_q <= ie_fall_d;
      sync_q    <= sync_d;
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_bit
    ahb_gpio_irq_edge u_edge (
      .clk     (HCLK),
      .rst     (HRESET),
      .sync_in (sync_in[g]),
      .ie_rise (ie_rise_q[g]),
      .ie_fall (ie_fall_q[g]),
      .clr     (status_clr[g]),
      .status  (status[g])
    );
  end

  always_comb begin
    rval   = '0;
    HRDATA = '0;
    if (dph_q.valid && !dph_q.write) begin
      case (dph_q.off)
        OFF_DATA:    rval = (dir_q & out_q) | (~dir_q & sync_in);
        OFF_DIR:     rval = dir_q;
        OFF_IE_RISE: rval = ie_rise_q;
        OFF_IE_FALL: rval = ie_fall_q;
        OFF_STATUS:  rval = status;
        default:     rval = '0;
      endcase
    end
    HRDATA[W-1:0] = rval;
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIOOUT   = out_q;
  assign GPIOEN    = dir_q;
  assign IRQ       = |status;

  // Bus bits the decoder never looks at.
  logic unused_hwdata;
  if (W < 32) begin : g_hw_part
    assign unused_hwdata = ^HWDATA[31:W];
  end else begin : g_hw_full
    assign unused_hwdata = 1'b0;
  end
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], unused_hwdata};
endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed bench: 16-bit/2-stage main instance plus 1/8/32-bit 3-stage instances
// sharing one bus, so every write lands in all four.

module tb_ahb_gpio_irq;
  localparam int SS = 2;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;

  logic [15:0] gin16;
  logic [0:0]  gin1;
  logic [7:0]  gin8;
  logic [31:0] gin32;

  logic [31:0] rdata_m, rdata_1, rdata_8, rdata_32;
  logic [15:0] out_m, en_m;
  logic [0:0]  out_1, en_1;
  logic [7:0]  out_8, en_8;
  logic [31:0] out_32, en_32;
  logic        hrdy_m, hrdy_1, hrdy_8, hrdy_32;
  logic        hresp_m, hresp_1, hresp_8, hresp_32;
  logic        irq_m, irq_1, irq_8, irq_32;

  logic [31:0] rd_m, rd_1, rd_8, rd_32;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 HCLK = ~HCLK;

  ahb_gpio_irq #(.GPIO_WIDTH(16), .SYNC_STAGES(SS)) dut_m (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .GPIOIN(gin16),
    .HREADYOUT(hrdy_m), .HRESP(hresp_m), .HRDATA(rdata_m), .GPIOOUT(out_m),
    .GPIOEN(en_m), .IRQ(irq_m));

  ahb_gpio_irq #(.GPIO_WIDTH(1), .SYNC_STAGES(3)) dut_1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .GPIOIN(gin1),
    .HREADYOUT(hrdy_1), .HRESP(hresp_1), .HRDATA(rdata_1), .GPIOOUT(out_1),
    .GPIOEN(en_1), .IRQ(irq_1));

  ahb_gpio_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(3)) dut_8 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .GPIOIN(gin8),
    .HREADYOUT(hrdy_8), .HRESP(hresp_8), .HRDATA(rdata_8), .GPIOOUT(out_8),
    .GPIOEN(en_8), .IRQ(irq_8));

  ahb_gpio_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(3)) dut_32 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .GPIOIN(gin32),
    .HREADYOUT(hrdy_32), .HRESP(hresp_32), .HRDATA(rdata_32), .GPIOOUT(out_32),
    .GPIOEN(en_32), .IRQ(irq_32));

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] tr = 2'b10);
    HSEL = 1'b1; HTRANS = tr; HWRITE = 1'b1; HADDR = a;
    step();
    bus_idle(); HWDATA = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    step();
    bus_idle();
    rd_m = rdata_m; rd_1 = rdata_1; rd_8 = rdata_8; rd_32 = rdata_32;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HREADY = 1'b1; HADDR = '0; HWDATA = '0; bus_idle();
    gin16 = '0; gin1 = '0; gin8 = '0; gin32 = '0;
    repeat (3) step();
    HRESET = 1'b0;
    step();
    n_checks++; if (en_m !== 16'h0) $display("FAIL reset_gpioen: got %h expected 0000", en_m); else n_pass++;
    n_checks++; if (out_m !== 16'h0) $display("FAIL reset_gpioout: got %h expected 0000", out_m); else n_pass++;
    n_checks++; if (irq_m !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_m); else n_pass++;
    n_checks++; if (rdata_m !== 32'h0) $display("FAIL reset_hrdata: got %h expected 0", rdata_m); else n_pass++;
    n_checks++; if (hrdy_m !== 1'b1) $display("FAIL reset_hreadyout: got %b expected 1", hrdy_m); else n_pass++;
    n_checks++; if (hresp_m !== 1'b0) $display("FAIL reset_hresp: got %b expected 0", hresp_m); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd(32'(i * 4));
      n_checks++; if (rd_m !== 32'h0) $display("FAIL reset_read off=%0h: got %h expected 0", i * 4, rd_m); else n_pass++;
    end
    // Write to DIR whose data phase collides with reset.
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
    step();
    bus_idle(); HWDATA = 32'hFFFF; HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    n_checks++; if (en_m !== 16'h0) $display("FAIL reset_inflight_en: got %h expected 0000", en_m); else n_pass++;
    rd(32'h4);
    n_checks++; if (rd_m !== 32'h0) $display("FAIL reset_inflight_dir: got %h expected 0", rd_m); else n_pass++;
  endtask

  task automatic test_no_spurious();
    gin16 = 16'hFFFF; gin1 = 1'b1; gin8 = 8'hFF; gin32 = 32'hFFFF_FFFF;
    HRESET = 1'b1;
    repeat (2) step();
    HRESET = 1'b0;
    repeat (6) step();
    n_checks++; if (irq_m !== 1'b0) $display("FAIL nospur_irq: got %b expected 0", irq_m); else n_pass++;
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h0) $display("FAIL nospur_status: got %h expected 0", rd_m); else n_pass++;
    gin16 = '0; gin1 = '0; gin8 = '0; gin32 = '0;
    repeat (6) step();
  endtask

  task automatic test_dir_data();
    wr(32'h4, 32'h00FF);
    wr(32'h0, 32'hA5A5);
    n_checks++; if (out_m !== 16'hA5A5) $display("FAIL dd_gpioout: got %h expected a5a5", out_m); else n_pass++;
    n_checks++; if (en_m !== 16'h00FF) $display("FAIL dd_gpioen: got %h expected 00ff", en_m); else n_pass++;
    gin16 = 16'h3C00;
    repeat (4) step();
    rd(32'h0);
    n_checks++; if (rd_m !== 32'h3CA5) $display("FAIL dd_data_read: got %h expected 3ca5", rd_m); else n_pass++;
    rd(32'h4);
    n_checks++; if (rd_m !== 32'h00FF) $display("FAIL dd_dir_read: got %h expected 00ff", rd_m); else n_pass++;
  endtask

  task automatic test_set_clr();
    wr(32'h0, 32'h00F0);
    wr(32'h8, 32'h000F);
    n_checks++; if (out_m !== 16'h00FF) $display("FAIL outset: got %h expected 00ff", out_m); else n_pass++;
    wr(32'hC, 32'h00F0);
    n_checks++; if (out_m !== 16'h000F) $display("FAIL outclr: got %h expected 000f", out_m); else n_pass++;
    rd(32'h8);
    n_checks++; if (rd_m !== 32'h0) $display("FAIL outset_read: got %h expected 0", rd_m); else n_pass++;
    rd(32'hC);
    n_checks++; if (rd_m !== 32'h0) $display("FAIL outclr_read: got %h expected 0", rd_m); else n_pass++;
    rd(32'h0);
    n_checks++; if (rd_m !== 32'h3C0F) $display("FAIL setclr_data_read: got %h expected 3c0f", rd_m); else n_pass++;
  endtask

  task automatic test_irq();
    gin16 = 16'h0;
    repeat (4) step();
    wr(32'h10, 32'h1);
    wr(32'h14, 32'h2);
    rd(32'h10);
    n_checks++; if (rd_m !== 32'h1) $display("FAIL ie_rise_read: got %h expected 1", rd_m); else n_pass++;
    rd(32'h14);
    n_checks++; if (rd_m !== 32'h2) $display("FAIL ie_fall_read: got %h expected 2", rd_m); else n_pass++;
    gin16 = 16'h0003;
    repeat (SS) @(posedge HCLK);
    #1;
    n_checks++; if (irq_m !== 1'b0) $display("FAIL irq_early: got %b expected 0", irq_m); else n_pass++;
    step();
    n_checks++; if (irq_m !== 1'b1) $display("FAIL irq_on_time: got %b expected 1", irq_m); else n_pass++;
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h1) $display("FAIL status_rise: got %h expected 1", rd_m); else n_pass++;
    gin16 = 16'h0001;
    repeat (SS + 2) step();
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h3) $display("FAIL status_fall: got %h expected 3", rd_m); else n_pass++;
    wr(32'h14, 32'h0);
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h3) $display("FAIL status_keep_ie_off: got %h expected 3", rd_m); else n_pass++;
    wr(32'h18, 32'h1);
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h2) $display("FAIL status_w1c: got %h expected 2", rd_m); else n_pass++;
    n_checks++; if (irq_m !== 1'b1) $display("FAIL irq_still_high: got %b expected 1", irq_m); else n_pass++;
    wr(32'h18, 32'h2);
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h0) $display("FAIL status_all_clear: got %h expected 0", rd_m); else n_pass++;
    n_checks++; if (irq_m !== 1'b0) $display("FAIL irq_low: got %b expected 0", irq_m); else n_pass++;
  endtask

  task automatic test_set_wins();
    gin16 = 16'h0;
    repeat (4) step();
    gin16 = 16'h0001;
    repeat (SS - 1) step();
    wr(32'h18, 32'h1);
    n_checks++; if (irq_m !== 1'b1) $display("FAIL setwins_irq: got %b expected 1", irq_m); else n_pass++;
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h1) $display("FAIL setwins_status: got %h expected 1", rd_m); else n_pass++;
    wr(32'h18, 32'h1);
    rd(32'h18);
    n_checks++; if (rd_m !== 32'h0) $display("FAIL setwins_clear_after: got %h expected 0", rd_m); else n_pass++;
  endtask

  task automatic test_back_to_back();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
    step();
    HWDATA = 32'h1234; HWRITE = 1'b0;
    step();
    bus_idle();
    rd_m = rdata_m; rd_32 = rdata_32;
    n_checks++; if (rd_m !== 32'h1234) $display("FAIL b2b_dir_m: got %h expected 1234", rd_m); else n_pass++;
    n_checks++; if (rd_32 !== 32'h1234) $display("FAIL b2b_dir_32: got %h expected 1234", rd_32); else n_pass++;
    n_checks++; if (en_m !== 16'h1234) $display("FAIL b2b_gpioen: got %h expected 1234", en_m); else n_pass++;
    wr(32'h10, 32'h00FF, 2'b11);
    rd(32'h10);
    n_checks++; if (rd_m !== 32'h00FF) $display("FAIL seq_write: got %h expected 00ff", rd_m); else n_pass++;
  endtask

  task automatic test_sweep();
    wr(32'h4, 32'hFFFF_FFFF);
    rd(32'h4);
    n_checks++; if (rd_m !== 32'h0000_FFFF) $display("FAIL sweep_w16_upper: got %h expected 0000ffff", rd_m); else n_pass++;
    n_checks++; if (rd_1 !== 32'h1) $display("FAIL sweep_w1_upper: got %h expected 1", rd_1); else n_pass++;
    n_checks++; if (rd_8 !== 32'hFF) $display("FAIL sweep_w8_upper: got %h expected ff", rd_8); else n_pass++;
    n_checks++; if (rd_32 !== 32'hFFFF_FFFF) $display("FAIL sweep_w32_full: got %h expected ffffffff", rd_32); else n_pass++;
    wr(32'h4, 32'h0);
    // IDLE, BUSY and HREADY-low address phases must not write DIR.
    for (int k = 0; k < 3; k++) begin
      HSEL = 1'b1; HWRITE = 1'b1; HADDR = 32'h4;
      HTRANS = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      HREADY = (k == 2) ? 1'b0 : 1'b1;
      step();
      bus_idle(); HREADY = 1'b1; HWDATA = 32'hFFFF_FFFF;
      step();
    end
    n_checks++; if (en_m !== 16'h0) $display("FAIL noaccess_w16: got %h expected 0", en_m); else n_pass++;
    n_checks++; if (en_1 !== 1'b0) $display("FAIL noaccess_w1: got %h expected 0", en_1); else n_pass++;
    n_checks++; if (en_8 !== 8'h0) $display("FAIL noaccess_w8: got %h expected 0", en_8); else n_pass++;
    n_checks++; if (en_32 !== 32'h0) $display("FAIL noaccess_w32: got %h expected 0", en_32); else n_pass++;
    gin1 = 1'b1; gin8 = 8'h5A; gin32 = 32'hDEAD_BEEF;
    step();
    rd(32'h0);
    n_checks++; if (rd_1 !== 32'h0) $display("FAIL lat3_early_w1: got %h expected 0", rd_1); else n_pass++;
    n_checks++; if (rd_8 !== 32'h0) $display("FAIL lat3_early_w8: got %h expected 0", rd_8); else n_pass++;
    n_checks++; if (rd_32 !== 32'h0) $display("FAIL lat3_early_w32: got %h expected 0", rd_32); else n_pass++;
    rd(32'h0);
    n_checks++; if (rd_1 !== 32'h1) $display("FAIL lat3_w1: got %h expected 1", rd_1); else n_pass++;
    n_checks++; if (rd_8 !== 32'h5A) $display("FAIL lat3_w8: got %h expected 5a", rd_8); else n_pass++;
    n_checks++; if (rd_32 !== 32'hDEAD_BEEF) $display("FAIL lat3_w32: got %h expected deadbeef", rd_32); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_spurious();
    test_dir_data();
    test_set_clr();
    test_irq();
    test_set_wins();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
